// File: rtl/cp0_reg.sv
// ---------------------------------------------------------------------------
// cp0_reg -- MIPS Coprocessor-0 register file.
//
// Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14)
// and the constant PRId(15). mtc0 writes come from WB. Exception and eret
// updates come from MEM. Reads are a purely combinational mux with no write
// bypass, because EX forwards in-flight CP0 writes itself.
//
// Build option: define CP0_TIMER_EN to include the Count/Compare timer.
// Without it, Count and Compare read 0, their writes are dropped, and
// timer_int_o is tied to 0.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i  mtc0 write port
//   raddr_i -> rdata_o    combinational read port
//   int_i[5:0]            level-sensitive hardware interrupt lines
//   exception_type_i      [31] valid, [4:0] ExcCode; 32'h8000_000E is eret
//   current_instr_addr_i  PC of the excepting instruction
//   is_in_delayslot_i     excepting instruction sits in a delay slot
//   bad_vaddr_i           faulting address for AdEL/AdES
//   count_o .. badvaddr_o live register values
//   timer_int_o           sticky timer interrupt
//
// Handshake: there is no valid/ready pairing. A write with we_i high and an
// exception with exception_type_i[31] high are each accepted at the rising
// edge where they are present. When both occur in the same cycle, the
// exception fields override the mtc0 write.
// ---------------------------------------------------------------------------
module cp0_reg #(
  parameter logic [31:0] PRID = 32'h0000_4220
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] exception_type_i,
  input  logic [31:0] current_instr_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_vaddr_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
  localparam logic [4:0]  ADDR_COUNT    = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
  localparam logic [4:0]  ADDR_STATUS   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
  localparam logic [4:0]  ADDR_EPC      = 5'd14;
  localparam logic [4:0]  ADDR_PRID     = 5'd15;

  localparam logic [31:0] STATUS_RESET  = 32'h0040_0000;
  // IM[15:8], EXL[1] and IE[0] are the only Status bits that software can write.
  localparam logic [31:0] STATUS_WMASK  = 32'h0000_FF03;
  localparam logic [31:0] ERET_CODE     = 32'h8000_000E;

  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic [31:0] status_q,   status_d;
  logic [31:0] epc_q,      epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        timer_q,    timer_d;
  // Cause is stored as its live fields only. TI is a mirror of timer_q.
  logic        bd_q,       bd_d;
  logic [7:0]  ip_q,       ip_d;
  logic [4:0]  exc_q,      exc_d;

  logic wr_count, wr_compare, exc_take, exc_eret;

  assign wr_count   = we_i && (waddr_i == ADDR_COUNT);
  assign wr_compare = we_i && (waddr_i == ADDR_COMPARE);
  assign exc_eret   = (exception_type_i == ERET_CODE);
  assign exc_take   = exception_type_i[31] && !exc_eret;

  // ---------------------------------------------------------------------
  // Next-state logic. The mtc0 write is applied first. Exception and eret
  // updates then overwrite only the fields they own. Decisions about EPC
  // and BD use the EXL value from before this cycle (status_q).
  // ---------------------------------------------------------------------
  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    bd_d       = bd_q;
    exc_d      = exc_q;
    ip_d       = ip_q;

    if (we_i) begin
      case (waddr_i)
        ADDR_STATUS: status_d = (wdata_i & STATUS_WMASK) | STATUS_RESET;
        ADDR_CAUSE:  ip_d[1:0] = wdata_i[9:8];
        ADDR_EPC:    epc_d = wdata_i;
        default: ;
      endcase
    end

    // Hardware interrupt pending bits follow the input lines every cycle.
    // IP7 is shared between int_i[5] and the timer.
    ip_d[7:2] = {int_i[5] | timer_q, int_i[4:0]};

    if (exc_take) begin
      exc_d       = exception_type_i[4:0];
      status_d[1] = 1'b1;
      if (!status_q[1]) begin
        epc_d = is_in_delayslot_i ? (current_instr_addr_i - 32'd4)
                                  : current_instr_addr_i;
        bd_d  = is_in_delayslot_i;
      end
      if (exception_type_i[4:0] == 5'd4 || exception_type_i[4:0] == 5'd5)
        badvaddr_d = bad_vaddr_i;
    end else if (exc_eret) begin
      status_d[1] = 1'b0;
    end
  end

`ifdef CP0_TIMER_EN
  // A write to Count replaces the increment for that cycle. A write to
  // Compare clears the interrupt, and the clear wins over a same-cycle match.
  always_comb begin
    count_d   = wr_count ? wdata_i : (count_q + 32'd1);
    compare_d = wr_compare ? wdata_i : compare_q;
    timer_d   = timer_q;
    if (wr_compare)
      timer_d = 1'b0;
    else if (count_q == compare_q)
      timer_d = 1'b1;
  end
`else
  always_comb begin
    count_d   = '0;
    compare_d = '0;
    timer_d   = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------
  // State registers. Reset discards every update pending in that cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      compare_q  <= '0;
      status_q   <= STATUS_RESET;
      epc_q      <= '0;
      badvaddr_q <= '0;
      timer_q    <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_q      <= '0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      timer_q    <= timer_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_q      <= exc_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs and the read mux
  // ---------------------------------------------------------------------
  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = {bd_q, timer_q, 14'd0, ip_q, 1'b0, exc_q, 2'b00};
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = timer_q;

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      ADDR_BADVADDR: rdata_o = badvaddr_q;
      ADDR_COUNT:    rdata_o = count_q;
      ADDR_COMPARE:  rdata_o = compare_q;
      ADDR_STATUS:   rdata_o = status_q;
      ADDR_CAUSE:    rdata_o = cause_o;
      ADDR_EPC:      rdata_o = epc_q;
      ADDR_PRID:     rdata_o = PRID;
      default:       rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_reg.sv
module tb_cp0_reg;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        we_i = 1'b0;
  logic [4:0]  waddr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [4:0]  raddr_i = '0;
  logic [31:0] rdata_o;
  logic [5:0]  int_i = '0;
  logic [31:0] exception_type_i = '0;
  logic [31:0] current_instr_addr_i = '0;
  logic        is_in_delayslot_i = 1'b0;
  logic [31:0] bad_vaddr_i = '0;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
  logic        timer_int_o;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  cp0_reg #(.PRID(32'h0000_4220)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o),
    .int_i(int_i), .exception_type_i(exception_type_i),
    .current_instr_addr_i(current_instr_addr_i),
    .is_in_delayslot_i(is_in_delayslot_i), .bad_vaddr_i(bad_vaddr_i),
    .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
    .timer_int_o(timer_int_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0;
  endtask

  task automatic raise_exc(input logic [31:0] t, input logic [31:0] pc,
                           input logic ds, input logic [31:0] bv);
    exception_type_i = t; current_instr_addr_i = pc;
    is_in_delayslot_i = ds; bad_vaddr_i = bv;
    tick();
    exception_type_i = '0;
  endtask

  // scoreboard: expectation queued when the read is issued, popped when sampled
  task automatic check_rd(input string tag, input logic [4:0] a, input logic [31:0] e);
    logic [31:0] x;
    exp_q.push_back(e);
    raddr_i = a;
    #1;
    x = exp_q.pop_front();
    total++;
    assert (rdata_o === x)
      else begin
        bad++;
        $error("FAIL %s got=%h exp=%h", tag, rdata_o, x);
      end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic e);
    logic [31:0] x;
    exp_q.push_back({31'd0, e});
    #1;
    x = exp_q.pop_front();
    total++;
    assert ({31'd0, got} === x)
      else begin
        bad++;
        $error("FAIL %s got=%b exp=%b", tag, got, x[0]);
      end
  endtask

  initial begin
    // reset state, sampled while reset is still held
    tick(); tick();
    check_rd("rst_badvaddr", 5'd8,  32'h0);
    check_rd("rst_count",    5'd9,  32'h0);
    check_rd("rst_compare",  5'd11, 32'h0);
    check_rd("rst_status",   5'd12, 32'h0040_0000);
    check_rd("rst_cause",    5'd13, 32'h0);
    check_rd("rst_epc",      5'd14, 32'h0);
    check_rd("rst_prid",     5'd15, 32'h0000_4220);
    check_bit("rst_timer", timer_int_o, 1'b0);
    rst_i = 1'b0;

    // Move Compare far away so the reset-time Count==Compare match is cleared.
    mtc0(5'd11, 32'hFFFF_0000);
    tick();

    // writable masks
    mtc0(5'd12, 32'hFFFF_FFFF);
    check_rd("status_mask", 5'd12, 32'h0040_FF03);
    mtc0(5'd13, 32'hFFFF_FFFF);
    check_rd("cause_mask", 5'd13, 32'h0000_0300);
    mtc0(5'd8, 32'h1234_5678);
    check_rd("badvaddr_ro", 5'd8, 32'h0);
    mtc0(5'd3, 32'hDEAD_BEEF);
    check_rd("unmapped", 5'd3, 32'h0);
    mtc0(5'd14, 32'hA5A5_0000);
    check_rd("epc_wr", 5'd14, 32'hA5A5_0000);
    mtc0(5'd12, 32'h0);
    mtc0(5'd13, 32'h0);

    // exception in a delay slot
    raise_exc(32'h8000_0004, 32'hBFC0_0100, 1'b1, 32'h0000_0003);
    check_rd("exc1_epc",    5'd14, 32'hBFC0_00FC);
    check_rd("exc1_cause",  5'd13, 32'h8000_0010);
    check_rd("exc1_status", 5'd12, 32'h0040_0002);
    check_rd("exc1_badva",  5'd8,  32'h0000_0003);

    // nested exception: EPC/BD held, ExcCode updated
    raise_exc(32'h8000_0008, 32'h0000_1000, 1'b0, 32'h0000_0077);
    check_rd("exc2_epc",   5'd14, 32'hBFC0_00FC);
    check_rd("exc2_cause", 5'd13, 32'h8000_0020);
    check_rd("exc2_badva", 5'd8,  32'h0000_0003);

    // eret
    raise_exc(32'h8000_000E, 32'h0000_2222, 1'b0, 32'h0);
    check_rd("eret_status", 5'd12, 32'h0040_0000);
    check_rd("eret_cause",  5'd13, 32'h8000_0020);

    // same-cycle mtc0 Status and exception
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0000_0001;
    raise_exc(32'h8000_000C, 32'h0000_2000, 1'b0, 32'h0);
    we_i = 1'b0;
    check_rd("same_status", 5'd12, 32'h0040_0003);
    check_rd("same_epc",    5'd14, 32'h0000_2000);
    check_rd("same_cause",  5'd13, 32'h0000_0030);

    // hardware interrupt lines
    int_i = 6'b10_0001;
    tick();
    check_rd("int_ip", 5'd13, 32'h0000_8430);
    int_i = '0;
    tick();
    check_rd("int_clr", 5'd13, 32'h0000_0030);

`ifdef CP0_TIMER_EN
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd5);
    check_rd("cnt_load", 5'd9, 32'd5);
    repeat (5) tick();
    check_rd("cnt_10", 5'd9, 32'd10);
    check_bit("tmr_pre", timer_int_o, 1'b0);
    tick();
    check_bit("tmr_set", timer_int_o, 1'b1);
    check_rd("tmr_ti", 5'd13, 32'h4000_0030);
    tick();
    check_rd("tmr_ip7", 5'd13, 32'h4000_8030);
    mtc0(5'd11, 32'h0000_FFFF);
    check_bit("tmr_clr", timer_int_o, 1'b0);
    tick();
    check_rd("tmr_cause_clr", 5'd13, 32'h0000_0030);
    mtc0(5'd9, 32'hFFFF_FFFF);
    tick();
    check_rd("cnt_wrap", 5'd9, 32'h0);
`else
    mtc0(5'd11, 32'd10);
    check_rd("cmp_off", 5'd11, 32'h0);
    mtc0(5'd9, 32'd5);
    repeat (12) tick();
    check_rd("cnt_off", 5'd9, 32'h0);
    check_bit("tmr_off", timer_int_o, 1'b0);
    check_rd("cause_off", 5'd13, 32'h0000_0030);
`endif

    // reset mid-operation discards pending updates
    rst_i = 1'b1;
    we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h1357_9BDF;
    raise_exc(32'h8000_0004, 32'h0000_4000, 1'b1, 32'h0000_00FF);
    we_i = 1'b0;
    check_rd("rst2_epc",    5'd14, 32'h0);
    check_rd("rst2_status", 5'd12, 32'h0040_0000);
    check_rd("rst2_cause",  5'd13, 32'h0);
    check_rd("rst2_badva",  5'd8,  32'h0);
    rst_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
